// File: rtl/cpu_mem_phase_sequencer.sv
// CPU/SRAM clock-enable phase sequencer with two programmable interrupt timer
// channels (IRQ = channel 0, NMI = channel 1) for 6502-class system benches.
module cpu_mem_phase_sequencer #(
    parameter int CNT_WIDTH    = 16,
    parameter int PHASE_BITS   = 2,
    parameter int PERIOD_WIDTH = 16,
    parameter int PULSE_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clk__enable,
    input  logic                    run,
    input  logic [PHASE_BITS-1:0]   phase_max,
    input  logic                    cfg_write,
    input  logic                    cfg_sel,
    input  logic [1:0]              cfg_mode,
    input  logic [PERIOD_WIDTH-1:0] cfg_period,
    input  logic [PULSE_WIDTH-1:0]  cfg_pulse,
    input  logic [1:0]              int_ack,
    output logic                    cpu_clk_enable,
    output logic                    sram_clk_enable,
    output logic [CNT_WIDTH-1:0]    cpu_cycle,
    output logic                    irq_n,
    output logic                    nmi_n,
    output logic [3:0]              chan_mode
);
    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_LEVEL    = 2'b11
    } mode_t;

    localparam logic [PHASE_BITS-1:0]   PH_ONE  = {{(PHASE_BITS-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PULSE_WIDTH-1:0]  PUL_ONE = {{(PULSE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]    CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [PHASE_BITS-1:0]   phase;
    logic [PHASE_BITS-1:0]   pm;
    logic                    adv;
    mode_t                   mode       [2];
    logic [PERIOD_WIDTH-1:0] period     [2];
    logic [PERIOD_WIDTH-1:0] timer      [2];
    logic [PERIOD_WIDTH-1:0] reload     [2];
    logic [PULSE_WIDTH-1:0]  pulse      [2];
    logic [PULSE_WIDTH-1:0]  pcnt       [2];
    logic [PULSE_WIDTH-1:0]  pulse_init [2];
    logic [PERIOD_WIDTH-1:0] load_timer;
    logic [1:0]              line_n;
    logic [1:0]              fired;
    logic [1:0]              load;
    logic [1:0]              fire;

    assign pm  = (phase_max == '0) ? PH_ONE : phase_max;
    assign adv = clk__enable & run;

    // Enables are held off while reset is asserted so nothing downstream steps.
    assign cpu_clk_enable  = adv & reset_n & (phase == '0);
    assign sram_clk_enable = adv & reset_n & (phase == pm);

    assign load_timer = (cfg_period == '0) ? '0 : cfg_period - PER_ONE;

    always_comb begin
        load       = '0;
        fire       = '0;
        reload     = '{default: '0};
        pulse_init = '{default: '0};
        for (int c = 0; c < 2; c++) begin
            reload[c]     = (period[c] == '0) ? '0 : period[c] - PER_ONE;
            pulse_init[c] = (pulse[c] == '0) ? '0 : pulse[c] - PUL_ONE;
            load[c]       = clk__enable & cfg_write & (int'(cfg_sel) == c);
            // A one-shot channel fires only once per configuration.
            fire[c] = cpu_clk_enable & (mode[c] != MODE_OFF) & (timer[c] == '0)
                      & ~((mode[c] == MODE_ONESHOT) & fired[c]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= '0;
            cpu_cycle <= '0;
            line_n    <= 2'b11;
            fired     <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                mode[c]   <= MODE_OFF;
                period[c] <= '0;
                timer[c]  <= '0;
                pulse[c]  <= '0;
                pcnt[c]   <= '0;
            end
        end else begin
            if (adv) phase <= (phase >= pm) ? '0 : phase + PH_ONE;
            if (cpu_clk_enable) cpu_cycle <= cpu_cycle + CNT_ONE;
            for (int c = 0; c < 2; c++) begin
                if (load[c]) begin
                    mode[c]   <= mode_t'(cfg_mode);
                    period[c] <= cfg_period;
                    pulse[c]  <= cfg_pulse;
                    timer[c]  <= load_timer;
                    pcnt[c]   <= '0;
                    line_n[c] <= 1'b1;
                    fired[c]  <= 1'b0;
                end else if (cpu_clk_enable && mode[c] != MODE_OFF) begin
                    timer[c] <= (timer[c] == '0) ? reload[c] : timer[c] - PER_ONE;
                    if (fire[c]) begin
                        line_n[c] <= 1'b0;
                        fired[c]  <= 1'b1;
                        pcnt[c]   <= pulse_init[c];
                    end else if (mode[c] == MODE_LEVEL) begin
                        if (int_ack[c]) line_n[c] <= 1'b1;
                    end else if (!line_n[c]) begin
                        if (pcnt[c] == '0) begin
                            line_n[c] <= 1'b1;
                            if (mode[c] == MODE_ONESHOT) mode[c] <= MODE_OFF;
                        end else begin
                            pcnt[c] <= pcnt[c] - PUL_ONE;
                        end
                    end
                end
            end
        end
    end

    assign irq_n     = line_n[0];
    assign nmi_n     = line_n[1];
    assign chan_mode = {mode[1], mode[0]};
endmodule
